// File: rtl/mac_if_pkg.sv
// Shared widths, beat/word types and the last-word keep helper for the
// engine-to-MAC transmit serializer.
package mac_if_pkg;

  localparam int IN_W   = 256;
  localparam int OUT_W  = 64;
  localparam int WORDS  = IN_W / OUT_W;
  localparam int SIZE_W = 11;
  localparam int PAD_W  = 5;
  localparam int KEEP_W = OUT_W / 8;
  localparam int BEAT_BYTES = IN_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic [IN_W-1:0]   data;
    logic              startframe;
    logic              endframe;
    logic [SIZE_W-1:0] frame_size;
    logic [PAD_W-1:0]  padbytes;
  } beat_t;

  typedef struct packed {
    logic [KEEP_W-1:0] keep;
    logic [2:0]        nwords;
  } keep_info_t;

  // Word count of an end beat, and the keep mask of word_idx within it
  // (all ones except on the final word, which is filled MSB-first).
  function automatic keep_info_t keep_from_pad(input logic [PAD_W-1:0] pad,
                                               input logic [1:0] word_idx);
    keep_info_t ki;
    logic [5:0] valid;
    valid     = 6'(BEAT_BYTES) - 6'(pad);
    ki.nwords = 3'((valid + 6'd7) >> 3);
    if ({1'b0, word_idx} == ki.nwords - 3'd1) begin
      if (valid[2:0] == 3'd0) ki.keep = '1;
      else                    ki.keep = ~(8'hFF >> valid[2:0]);
    end else begin
      ki.keep = '1;
    end
    return ki;
  endfunction

endpackage

// File: rtl/mac_tx_frame_serializer_if.sv
// Beat input (engine side) and word output (NoC side) handshake bundle.
interface mac_tx_frame_serializer_if;
  import mac_if_pkg::*;

  logic              engine_mac_tx_val;
  logic              mac_engine_tx_rdy;
  logic [IN_W-1:0]   engine_mac_tx_data;
  logic              engine_mac_tx_startframe;
  logic              engine_mac_tx_endframe;
  logic [SIZE_W-1:0] engine_mac_tx_frame_size;
  logic [PAD_W-1:0]  engine_mac_tx_padbytes;

  logic              out_val;
  logic              out_rdy;
  logic [OUT_W-1:0]  out_data;
  logic [KEEP_W-1:0] out_keep;
  logic              out_last;

  modport slave (
    input  engine_mac_tx_val, engine_mac_tx_data, engine_mac_tx_startframe,
           engine_mac_tx_endframe, engine_mac_tx_frame_size, engine_mac_tx_padbytes,
    output mac_engine_tx_rdy,
    output out_val, out_data, out_keep, out_last,
    input  out_rdy
  );

  modport master (
    output engine_mac_tx_val, engine_mac_tx_data, engine_mac_tx_startframe,
           engine_mac_tx_endframe, engine_mac_tx_frame_size, engine_mac_tx_padbytes,
    input  mac_engine_tx_rdy,
    input  out_val, out_data, out_keep, out_last,
    output out_rdy
  );

endinterface

// File: rtl/mac_word_out_reg.sv
// Single-entry output register slice; accepts a new word whenever empty or
// draining, so a ready sink sees one word per cycle.
module mac_word_out_reg
  import mac_if_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_val,
  output logic              o_rdy,
  input  logic [OUT_W-1:0]  i_data,
  input  logic [KEEP_W-1:0] i_keep,
  input  logic              i_last,
  output logic              o_val,
  input  logic              i_rdy,
  output logic [OUT_W-1:0]  o_data,
  output logic [KEEP_W-1:0] o_keep,
  output logic              o_last
);

  logic              r_val;
  logic [OUT_W-1:0]  r_data;
  logic [KEEP_W-1:0] r_keep;
  logic              r_last;

  assign o_rdy = !r_val || i_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val  <= 1'b0;
      r_data <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
    end else if (o_rdy) begin
      r_val <= i_val;
      if (i_val) begin
        r_data <= i_data;
        r_keep <= i_keep;
        r_last <= i_last;
      end
    end
  end

  assign o_val  = r_val;
  assign o_data = r_data;
  assign o_keep = r_keep;
  assign o_last = r_last;

endmodule

// File: rtl/mac_tx_frame_serializer.sv
// Serializes 256-bit engine frame beats into 64-bit words: optional header
// word with frame_size, then only valid payload bytes with keep/last.
module mac_tx_frame_serializer
  import mac_if_pkg::*;
#(
  parameter bit EMIT_HDR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  mac_tx_frame_serializer_if.slave bus,
  output logic [31:0]          frames_sent,
  output logic                 proto_err
);

  state_t            r_state, w_state_next;
  logic [IN_W-1:0]   r_buf_data, w_buf_data_next;
  logic              r_buf_end, w_buf_end_next;
  logic [PAD_W-1:0]  r_buf_pad, w_buf_pad_next;
  logic              r_buf_full, w_buf_full_next;
  logic [1:0]        r_idx, w_idx_next;
  logic [SIZE_W-1:0] r_frame_size, w_frame_size_next;
  logic              r_proto_err, w_proto_err_next;
  logic [31:0]       r_frames_sent;

  beat_t             w_beat;
  keep_info_t        w_ki;
  logic [OUT_W-1:0]  w_words [WORDS];
  logic              w_last_word;
  logic              w_word_val, w_word_rdy, w_word_hs, w_word_last;
  logic [OUT_W-1:0]  w_word_data;
  logic [KEEP_W-1:0] w_word_keep;
  logic              w_final_hs, w_frame_open;
  logic              w_in_rdy, w_in_hs;
  logic              w_out_val, w_out_last;
  logic [OUT_W-1:0]  w_out_data;
  logic [KEEP_W-1:0] w_out_keep;

  assign w_beat = '{data:       bus.engine_mac_tx_data,
                    startframe: bus.engine_mac_tx_startframe,
                    endframe:   bus.engine_mac_tx_endframe,
                    frame_size: bus.engine_mac_tx_frame_size,
                    padbytes:   bus.engine_mac_tx_padbytes};

  // Word 0 is the most significant slice of the beat (byte 0 first on the wire).
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      assign w_words[gi] = r_buf_data[IN_W-1-OUT_W*gi -: OUT_W];
    end
  endgenerate

  assign w_ki        = keep_from_pad(r_buf_pad, r_idx);
  assign w_last_word = r_buf_end ? ({1'b0, r_idx} == w_ki.nwords - 3'd1)
                                 : (r_idx == 2'(WORDS - 1));
  assign w_word_hs   = w_word_val && w_word_rdy;
  assign w_final_hs  = (r_state == ST_DATA) && r_buf_full && w_last_word && w_word_hs;
  assign w_frame_open = (r_state == ST_IDLE) || (w_final_hs && r_buf_end);
  assign w_in_rdy    = !rst && (r_state != ST_HDR) && (!r_buf_full || w_final_hs);
  assign w_in_hs     = bus.engine_mac_tx_val && w_in_rdy;

  assign bus.mac_engine_tx_rdy = w_in_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_buf_data   <= '0;
      r_buf_end    <= 1'b0;
      r_buf_pad    <= '0;
      r_buf_full   <= 1'b0;
      r_idx        <= '0;
      r_frame_size <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_buf_data   <= w_buf_data_next;
      r_buf_end    <= w_buf_end_next;
      r_buf_pad    <= w_buf_pad_next;
      r_buf_full   <= w_buf_full_next;
      r_idx        <= w_idx_next;
      r_frame_size <= w_frame_size_next;
      r_proto_err  <= w_proto_err_next;
    end
  end

  // Word presented to the output slice.
  always_comb begin
    w_word_val  = 1'b0;
    w_word_data = '0;
    w_word_keep = '0;
    w_word_last = 1'b0;
    case (r_state)
      ST_HDR: begin
        w_word_val  = 1'b1;
        w_word_data = {{(OUT_W-SIZE_W){1'b0}}, r_frame_size};
        w_word_keep = '1;
      end
      ST_DATA: begin
        if (r_buf_full) begin
          w_word_val  = 1'b1;
          w_word_data = w_words[r_idx];
          w_word_keep = r_buf_end ? w_ki.keep : '1;
          w_word_last = r_buf_end && w_last_word;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next      = r_state;
    w_buf_data_next   = r_buf_data;
    w_buf_end_next    = r_buf_end;
    w_buf_pad_next    = r_buf_pad;
    w_buf_full_next   = r_buf_full;
    w_idx_next        = r_idx;
    w_frame_size_next = r_frame_size;
    w_proto_err_next  = r_proto_err;

    case (r_state)
      ST_IDLE: ;
      ST_HDR: begin
        if (w_word_hs) begin
          w_state_next = ST_DATA;
          w_idx_next   = '0;
        end
      end
      ST_DATA: begin
        if (r_buf_full && w_word_hs) begin
          if (w_last_word) begin
            w_buf_full_next = 1'b0;
            w_idx_next      = '0;
            if (r_buf_end) w_state_next = ST_IDLE;
          end else begin
            w_idx_next = r_idx + 2'd1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Beat acceptance overrides the drain bookkeeping above (refill / new frame).
    if (w_in_hs) begin
      if (w_frame_open && !w_beat.startframe) begin
        w_proto_err_next = 1'b1;
      end else begin
        w_buf_data_next = w_beat.data;
        w_buf_end_next  = w_beat.endframe;
        w_buf_pad_next  = w_beat.padbytes;
        w_buf_full_next = 1'b1;
        w_idx_next      = '0;
        if (w_frame_open) begin
          w_frame_size_next = w_beat.frame_size;
          w_state_next      = EMIT_HDR ? ST_HDR : ST_DATA;
        end else if (w_beat.startframe) begin
          w_proto_err_next = 1'b1;
        end
      end
    end
  end

  mac_word_out_reg u_out_reg (
    .clk    (clk),
    .rst    (rst),
    .i_val  (w_word_val),
    .o_rdy  (w_word_rdy),
    .i_data (w_word_data),
    .i_keep (w_word_keep),
    .i_last (w_word_last),
    .o_val  (w_out_val),
    .i_rdy  (bus.out_rdy),
    .o_data (w_out_data),
    .o_keep (w_out_keep),
    .o_last (w_out_last)
  );

  assign bus.out_val  = w_out_val;
  assign bus.out_data = w_out_data;
  assign bus.out_keep = w_out_keep;
  assign bus.out_last = w_out_last;

  always_ff @(posedge clk) begin
    if (rst) r_frames_sent <= '0;
    else if (w_out_val && bus.out_rdy && w_out_last) r_frames_sent <= r_frames_sent + 32'd1;
  end

  assign frames_sent = r_frames_sent;
  assign proto_err   = r_proto_err;

endmodule
